// File: rtl/uart_pad_ctrl.sv
// rtl/uart_pad_ctrl.sv - 8N1 UART receiver decoding bytes into per-player paddle buttons
//
// Purpose:
//   Receives 8N1 serial frames with 16x oversampling and maps each good byte
//   onto per-player up/down button outputs. There are three release behaviours:
//   latch (MODE 0), hold with timeout (MODE 1) and single-cycle pulse (MODE 2).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   RsRx       serial input, idle high, asynchronous to clk
//   btn_up     per-player up level/pulse      [N_PLAYERS]
//   btn_dn     per-player down level/pulse    [N_PLAYERS]
//   key_valid  one-cycle strobe, good byte received
//   key_code   last good byte, stable until the next key_valid
//   frame_err  one-cycle strobe, stop bit sampled low

module uart_pad_ctrl #(
    parameter int                      CLK_HZ      = 100_000_000,
    parameter int                      BAUD        = 9600,
    parameter int                      N_PLAYERS   = 2,
    parameter logic [16*N_PLAYERS-1:0] KEY_MAP     = {8'h73, 8'h77, 8'h36, 8'h39},
    parameter int                      MODE        = 1,
    parameter int                      HOLD_CYCLES = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RsRx,
    output logic [N_PLAYERS-1:0] btn_up,
    output logic [N_PLAYERS-1:0] btn_dn,
    output logic                 key_valid,
    output logic [7:0]           key_code,
    output logic                 frame_err
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = $clog2(DIV + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rxState_t;

    logic             rxMeta;
    logic             rxSync;
    logic [DIV_W-1:0] tickCnt;
    logic             tick;

    rxState_t         state;
    rxState_t         stateNext;
    logic [3:0]       phase;
    logic [3:0]       phaseNext;
    logic [2:0]       bitIdx;
    logic [2:0]       bitNext;
    logic [7:0]       shiftReg;
    logic [7:0]       shiftNext;
    logic             byteGood;
    logic             byteBad;

    logic [N_PLAYERS-1:0]             upHit;
    logic [N_PLAYERS-1:0]             dnHit;
    logic [N_PLAYERS-1:0][HOLD_W-1:0] holdCnt;

    assign tick = (tickCnt == DIV_W'(DIV - 1));

    // Synchroniser, oversampling tick and receiver state registers.
    // The synchroniser resets to the idle (high) line level so a reset never
    // looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta    <= 1'b1;
            rxSync    <= 1'b1;
            tickCnt   <= '0;
            state     <= RX_IDLE;
            phase     <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            frame_err <= 1'b0;
        end else begin
            rxMeta    <= RsRx;
            rxSync    <= rxMeta;
            tickCnt   <= tick ? '0 : tickCnt + 1'b1;
            state     <= stateNext;
            phase     <= phaseNext;
            bitIdx    <= bitNext;
            shiftReg  <= shiftNext;
            key_valid <= byteGood;
            frame_err <= byteBad;
            if (byteGood) begin
                key_code <= shiftReg;
            end
        end
    end

    // Receiver next-state logic; everything advances on tick only.
    // START samples at half a bit (8 ticks) so DATA/STOP land mid-bit.
    always_comb begin
        stateNext = state;
        phaseNext = phase;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        byteGood  = 1'b0;
        byteBad   = 1'b0;
        if (tick) begin
            case (state)
                RX_IDLE: begin
                    if (!rxSync) begin
                        stateNext = RX_START;
                        phaseNext = '0;
                    end
                end
                RX_START: begin
                    if (phase == 4'd7) begin
                        phaseNext = '0;
                        bitNext   = '0;
                        stateNext = rxSync ? RX_IDLE : RX_DATA;
                    end else begin
                        phaseNext = phase + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (phase == 4'd15) begin
                        phaseNext = '0;
                        // LSB arrives first, so shift in from the top.
                        shiftNext = {rxSync, shiftReg[7:1]};
                        bitNext   = bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
                            stateNext = RX_STOP;
                        end
                    end else begin
                        phaseNext = phase + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (phase == 4'd15) begin
                        phaseNext = '0;
                        if (rxSync) begin
                            byteGood  = 1'b1;
                            stateNext = RX_IDLE;
                        end else begin
                            byteBad   = 1'b1;
                            stateNext = RX_BREAK;
                        end
                    end else begin
                        phaseNext = phase + 4'd1;
                    end
                end
                RX_BREAK: begin
                    // A held-low line stays here, so it can only ever produce one frame_err.
                    if (rxSync) begin
                        stateNext = RX_IDLE;
                    end
                end
                default: begin
                    stateNext = RX_IDLE;
                end
            endcase
        end
    end

    // Decode in the same cycle the byte is accepted so the buttons move together
    // with key_valid. The up code is tested first, so it wins a collision.
    always_comb begin
        upHit = '0;
        dnHit = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (byteGood && (shiftReg == KEY_MAP[16*p +: 8])) begin
                upHit[p] = 1'b1;
            end else if (byteGood && (shiftReg == KEY_MAP[16*p+8 +: 8])) begin
                dnHit[p] = 1'b1;
            end
        end
    end

    // Button levels. In hold mode the counter reloads on every match, so
    // keyboard autorepeat keeps the button held; both bits drop on the clock
    // the counter reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_up  <= '0;
            btn_dn  <= '0;
            holdCnt <= '0;
        end else begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                if (upHit[p]) begin
                    btn_up[p] <= 1'b1;
                    btn_dn[p] <= 1'b0;
                end else if (dnHit[p]) begin
                    btn_up[p] <= 1'b0;
                    btn_dn[p] <= 1'b1;
                end else if (MODE == 2) begin
                    btn_up[p] <= 1'b0;
                    btn_dn[p] <= 1'b0;
                end else if ((MODE == 1) && (holdCnt[p] == HOLD_W'(1))) begin
                    btn_up[p] <= 1'b0;
                    btn_dn[p] <= 1'b0;
                end

                if (MODE == 1) begin
                    if (upHit[p] || dnHit[p]) begin
                        holdCnt[p] <= HOLD_W'(HOLD_CYCLES);
                    end else if (holdCnt[p] != '0) begin
                        holdCnt[p] <= holdCnt[p] - 1'b1;
                    end
                end
            end
        end
    end

endmodule
